hs_elastic_buf: RTL

- Parametrised valid/ready elastic buffer. It is the next-generation source-to-destination handshake stage.
- Decouples a producer (s_* side) from a consumer (m_* side) with DEPTH entries of DATA_W-bit storage.
- Sustains one transfer per cycle on each side.
- No combinational path from m_ready_i to s_ready_o.
- Sits between any master/slave pair in the bus fabric. Its main use is timing-closure and stall isolation on long handshake paths.

---
 rtl/hs_pkg.sv | 11 +
 rtl/hs_elastic_mem.sv | 21 ++
 rtl/hs_elastic_buf.sv | 94 +++++++++
 3 files changed

// File: rtl/hs_pkg.sv
// Shared defaults and helpers for the hs_elastic_buf handshake stage.
package hs_pkg;
  localparam int HS_DATA_W = 8;
  localparam int HS_DEPTH  = 4;
  localparam int HS_STAT_W = 16;

  // Saturating increment for the 16-bit statistics counters.
  function automatic logic [HS_STAT_W-1:0] sat_inc(input logic [HS_STAT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction
endpackage

// File: rtl/hs_elastic_mem.sv
// DEPTH x DATA_W register file: synchronous write, asynchronous read.
module hs_elastic_mem #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);
  logic [DEPTH-1:0][DATA_W-1:0] mem;

  // Storage is not reset; the level counter decides what is valid.
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;

  assign rdata = mem[raddr];
endmodule

// File: rtl/hs_elastic_buf.sv
// Valid/ready elastic buffer with DEPTH entries; ready/valid come from registered state only.
// Optional statistics counters are enabled by defining HS_ELASTIC_BUF_STATS_EN.
module hs_elastic_buf
  import hs_pkg::*;
#(
  parameter int DATA_W = HS_DATA_W,
  parameter int DEPTH  = HS_DEPTH,
  parameter int CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush_i,
  input  logic                 s_valid_i,
  output logic                 s_ready_o,
  input  logic [DATA_W-1:0]    s_data_i,
  output logic                 m_valid_o,
  input  logic                 m_ready_i,
  output logic [DATA_W-1:0]    m_data_o,
  output logic [CNT_W-1:0]     level_o,
  output logic [HS_STAT_W-1:0] acc_cnt_o,
  output logic [HS_STAT_W-1:0] stall_cnt_o
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  level;
  logic              out_en;
  logic              push, pop;
  logic [DATA_W-1:0] rdata;

  // out_en keeps s_ready_o low through reset and rises on the first edge after release.
  assign s_ready_o = out_en & (level != CNT_W'(DEPTH));
  assign m_valid_o = (level != '0);
  assign m_data_o  = m_valid_o ? rdata : '0;
  assign level_o   = level;
  assign push      = s_valid_i & s_ready_o;
  assign pop       = m_valid_o & m_ready_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_en <= 1'b0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      out_en <= 1'b1;
      if (flush_i) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        level  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
        case ({push, pop})
          2'b10:   level <= level + 1'b1;
          2'b01:   level <= level - 1'b1;
          default: level <= level;
        endcase
      end
    end
  end

  hs_elastic_mem #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_mem (
    .clk   (clk),
    .we    (push & ~flush_i),
    .waddr (wr_ptr),
    .wdata (s_data_i),
    .raddr (rd_ptr),
    .rdata (rdata)
  );

`ifdef HS_ELASTIC_BUF_STATS_EN
  logic [HS_STAT_W-1:0] acc_cnt, stall_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_cnt   <= '0;
      stall_cnt <= '0;
    end else if (flush_i) begin
      acc_cnt   <= '0;
      stall_cnt <= '0;
    end else begin
      if (push)                   acc_cnt   <= sat_inc(acc_cnt);
      if (s_valid_i & ~s_ready_o) stall_cnt <= sat_inc(stall_cnt);
    end
  end

  assign acc_cnt_o   = acc_cnt;
  assign stall_cnt_o = stall_cnt;
`else
  assign acc_cnt_o   = '0;
  assign stall_cnt_o = '0;
`endif
endmodule
